// File: rtl/riscv_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, arbitration mode,
// default sizing and a modulo-increment helper for the round-robin pointer.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_e;

  localparam int XLEN_DEFAULT      = 32;
  localparam int NUM_PORTS_DEFAULT = 2;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// slave = the arbiter's view; master = the requesters plus memory around it.
interface mem_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int NUM_PORTS = 2
);
  // Handshakes: a request transfers on a cycle where valid and ready are both
  // high; valid may drop before ready without side effects. resp_valid and
  // mem_resp_valid are single-cycle pulses with no back-pressure.
  logic [NUM_PORTS-1:0]                 req_valid;
  logic [NUM_PORTS-1:0]                 req_ready;
  logic [NUM_PORTS-1:0]                 req_write;
  logic [NUM_PORTS-1:0][XLEN-1:0]       req_address;
  logic [NUM_PORTS-1:0][XLEN-1:0]       req_write_data;
  logic [NUM_PORTS-1:0][XLEN/8-1:0]     req_byte_enable;
  logic [NUM_PORTS-1:0]                 resp_valid;
  logic [XLEN-1:0]                      resp_read_data;

  logic                                 mem_valid;
  logic                                 mem_ready;
  logic                                 mem_write;
  logic [XLEN-1:0]                      mem_address;
  logic [XLEN-1:0]                      mem_write_data;
  logic [XLEN/8-1:0]                    mem_byte_enable;
  logic                                 mem_resp_valid;
  logic [XLEN-1:0]                      mem_read_data;

  modport slave (
    input  req_valid, req_write, req_address, req_write_data, req_byte_enable,
    output req_ready, resp_valid, resp_read_data,
    output mem_valid, mem_write, mem_address, mem_write_data, mem_byte_enable,
    input  mem_ready, mem_resp_valid, mem_read_data
  );

  modport master (
    output req_valid, req_write, req_address, req_write_data, req_byte_enable,
    input  req_ready, resp_valid, resp_read_data,
    input  mem_valid, mem_write, mem_address, mem_write_data, mem_byte_enable,
    output mem_ready, mem_resp_valid, mem_read_data
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection: scans the request vector from a start index
// (round-robin) or from index 0 (fixed) and returns a one-hot grant and index.
module rr_picker
  import riscv_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IW = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        start,
  input  arb_mode_e            mode,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IW-1:0]        index,
  output logic                 found
);

  int pos;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      pos = (mode == ARB_FIXED) ? off : int'(start) + off;
      if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
      if (!found && req[IW'(pos)]) begin
        found            = 1'b1;
        grant[IW'(pos)]  = 1'b1;
        index            = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multiplexes NUM_PORTS load/store requesters onto a single memory port with
// one transaction outstanding; the granted port receives the completion pulse.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int        XLEN      = XLEN_DEFAULT,
  parameter int        NUM_PORTS = NUM_PORTS_DEFAULT,
  parameter arb_mode_e ARB_MODE  = ARB_ROUND_ROBIN
) (
  input  logic         clk,
  input  logic         n_rst,
  mem_arbiter_if.slave bus,
  output arb_state_t   dbg_state
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int BW = XLEN / 8;

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        grant_q, last_grant_q, start_idx, pick_idx;
  logic [NUM_PORTS-1:0] pick_grant;
  logic                 pick_found;
  logic                 accept;

  logic                 write_q;
  logic [XLEN-1:0]      address_q, write_data_q;
  logic [BW-1:0]        byte_enable_q;

  logic [NUM_PORTS-1:0] req_ready_c, resp_valid_c;
  logic                 mem_valid_c;

  assign start_idx = IW'(wrap_inc(int'(last_grant_q), NUM_PORTS));

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req   (bus.req_valid),
    .start (start_idx),
    .mode  (ARB_MODE),
    .grant (pick_grant),
    .index (pick_idx),
    .found (pick_found)
  );

  // Gated by n_rst so no ready leaks out combinationally while reset is held.
  assign accept = (state_q == IDLE) && pick_found && n_rst;

  always_comb begin
    state_d      = state_q;
    req_ready_c  = '0;
    resp_valid_c = '0;
    mem_valid_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready_c = pick_grant;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid_c = 1'b1;
        if (bus.mem_ready) begin
          if (bus.mem_resp_valid) begin
            resp_valid_c[grant_q] = 1'b1;
            state_d               = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          resp_valid_c[grant_q] = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= IW'(NUM_PORTS - 1);
      write_q       <= 1'b0;
      address_q     <= '0;
      write_data_q  <= '0;
      byte_enable_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q       <= pick_idx;
        last_grant_q  <= pick_idx;
        write_q       <= bus.req_write[pick_idx];
        address_q     <= bus.req_address[pick_idx];
        write_data_q  <= bus.req_write_data[pick_idx];
        byte_enable_q <= bus.req_byte_enable[pick_idx];
      end
    end
  end

  assign bus.req_ready       = req_ready_c;
  assign bus.resp_valid      = resp_valid_c;
  assign bus.resp_read_data  = bus.mem_read_data;
  assign bus.mem_valid       = mem_valid_c;
  assign bus.mem_write       = write_q;
  assign bus.mem_address     = address_q;
  assign bus.mem_write_data  = write_data_q;
  assign bus.mem_byte_enable = byte_enable_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one fixed-priority
// instance, each scenario task checking its own hand-computed expectations.
module tb_mem_arbiter;
  import riscv_pkg::*;

  int errors = 0;
  int checks = 0;

  logic clk;
  logic n_rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32), .NUM_PORTS(2)) bus_rr ();
  mem_arbiter_if #(.XLEN(32), .NUM_PORTS(2)) bus_fx ();
  arb_state_t state_rr, state_fx;

  mem_arbiter #(.XLEN(32), .NUM_PORTS(2), .ARB_MODE(ARB_ROUND_ROBIN)) dut_rr (
    .clk(clk), .n_rst(n_rst), .bus(bus_rr), .dbg_state(state_rr));

  mem_arbiter #(.XLEN(32), .NUM_PORTS(2), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .n_rst(n_rst), .bus(bus_fx), .dbg_state(state_fx));

  task automatic init_inputs();
    bus_rr.req_valid = '0; bus_rr.req_write = '0; bus_rr.req_address = '0;
    bus_rr.req_write_data = '0; bus_rr.req_byte_enable = '0;
    bus_rr.mem_ready = 1'b0; bus_rr.mem_resp_valid = 1'b0; bus_rr.mem_read_data = '0;
    bus_fx.req_valid = '0; bus_fx.req_write = '0; bus_fx.req_address = '0;
    bus_fx.req_write_data = '0; bus_fx.req_byte_enable = '0;
    bus_fx.mem_ready = 1'b0; bus_fx.mem_resp_valid = 1'b0; bus_fx.mem_read_data = '0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    init_inputs();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [73:0] outs;
    n_rst = 1'b0;
    init_inputs();
    bus_rr.req_valid = 2'b11;
    bus_fx.req_valid = 2'b11;
    @(negedge clk);
    outs = {bus_rr.req_ready, bus_rr.resp_valid, bus_rr.mem_valid, bus_rr.mem_write,
            bus_rr.mem_address, bus_rr.mem_write_data, bus_rr.mem_byte_enable};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_rr_outputs: got %h want 0", outs); end
    outs = {bus_fx.req_ready, bus_fx.resp_valid, bus_fx.mem_valid, bus_fx.mem_write,
            bus_fx.mem_address, bus_fx.mem_write_data, bus_fx.mem_byte_enable};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_fx_outputs: got %h want 0", outs); end
    checks++;
    if (state_rr !== IDLE || state_fx !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d/%0d want IDLE", state_rr, state_fx);
    end
    init_inputs();
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_zero_wait_load();
    do_reset();
    @(posedge clk); #1;
    bus_rr.req_valid = 2'b01; bus_rr.req_write = 2'b00;
    bus_rr.req_address[0] = 32'h100; bus_rr.req_byte_enable[0] = 4'hF;
    bus_rr.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_rr.req_ready !== 2'b01 || bus_rr.mem_valid !== 1'b0) begin
      errors++; $display("FAIL load_accept: ready=%b mem_valid=%b want 01/0", bus_rr.req_ready, bus_rr.mem_valid);
    end
    @(posedge clk); #1;
    bus_rr.req_valid = 2'b00;
    bus_rr.mem_resp_valid = 1'b1; bus_rr.mem_read_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({bus_rr.mem_valid, bus_rr.mem_write, bus_rr.mem_address} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL load_issue: valid=%b write=%b addr=%h want 1/0/100",
                         bus_rr.mem_valid, bus_rr.mem_write, bus_rr.mem_address);
    end
    checks++;
    if (bus_rr.resp_valid !== 2'b01) begin
      errors++; $display("FAIL load_resp_valid: got %b want 01", bus_rr.resp_valid);
    end
    checks++;
    if (bus_rr.resp_read_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_read_data: got %h want deadbeef", bus_rr.resp_read_data);
    end
    checks++;
    if (bus_rr.mem_byte_enable !== 4'hF) begin
      errors++; $display("FAIL load_byte_enable: got %h want f", bus_rr.mem_byte_enable);
    end
    @(posedge clk); #1;
    bus_rr.mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state_rr !== IDLE || bus_rr.resp_valid !== 2'b00) begin
      errors++; $display("FAIL load_done: state=%0d resp=%b want IDLE/00", state_rr, bus_rr.resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[6] = '{0, 1, 0, 1, 0, 1};
    logic [1:0] expv;
    int cnt;
    bit got;
    do_reset();
    @(posedge clk); #1;
    bus_rr.mem_ready = 1'b1; bus_rr.mem_resp_valid = 1'b1; bus_rr.req_valid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      expv = 2'b01 << exp_g[t];
      cnt = 0; got = 1'b0;
      while (!got && cnt < 8) begin
        @(negedge clk); cnt++;
        if (bus_rr.req_ready != 2'b00) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL rr_grant_%0d: no grant within 8 cycles, want %b", t, expv);
      end else if (bus_rr.req_ready !== expv) begin
        errors++; $display("FAIL rr_grant_%0d: got %b want %b", t, bus_rr.req_ready, expv);
      end
      @(negedge clk);
      checks++;
      if (bus_rr.resp_valid !== expv) begin
        errors++; $display("FAIL rr_resp_%0d: got %b want %b", t, bus_rr.resp_valid, expv);
      end
    end
    init_inputs();
  endtask

  task automatic test_fixed();
    logic [1:0] exp_v[4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    int cnt;
    bit got;
    do_reset();
    @(posedge clk); #1;
    bus_fx.mem_ready = 1'b1; bus_fx.mem_resp_valid = 1'b1; bus_fx.req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      cnt = 0; got = 1'b0;
      while (!got && cnt < 8) begin
        @(negedge clk); cnt++;
        if (bus_fx.req_ready != 2'b00) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL fx_grant_%0d: no grant within 8 cycles, want %b", t, exp_v[t]);
      end else if (bus_fx.req_ready !== exp_v[t]) begin
        errors++; $display("FAIL fx_grant_%0d: got %b want %b", t, bus_fx.req_ready, exp_v[t]);
      end
      @(negedge clk);
      checks++;
      if (bus_fx.resp_valid !== exp_v[t]) begin
        errors++; $display("FAIL fx_resp_%0d: got %b want %b", t, bus_fx.resp_valid, exp_v[t]);
      end
      if (t == 2) bus_fx.req_valid = 2'b10;
    end
    init_inputs();
  endtask

  task automatic test_stall_store();
    logic [69:0] mem_bus;
    do_reset();
    @(posedge clk); #1;
    bus_rr.req_valid = 2'b10; bus_rr.req_write = 2'b10;
    bus_rr.req_address[1] = 32'h200; bus_rr.req_write_data[1] = 32'h12345678;
    bus_rr.req_byte_enable[1] = 4'hF; bus_rr.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_rr.req_ready !== 2'b10) begin
      errors++; $display("FAIL store_accept: got %b want 10", bus_rr.req_ready);
    end
    @(posedge clk); #1;
    bus_rr.req_address[1] = '0; bus_rr.req_write_data[1] = '0; bus_rr.req_byte_enable[1] = '0;
    for (int i = 0; i < 3; i++) begin
      // middle stall cycle: spurious completion plus a port0 request that vanishes
      bus_rr.mem_resp_valid = (i == 1);
      bus_rr.req_valid = (i == 1) ? 2'b01 : 2'b00;
      @(negedge clk);
      mem_bus = {bus_rr.mem_valid, bus_rr.mem_write, bus_rr.mem_address,
                 bus_rr.mem_write_data, bus_rr.mem_byte_enable};
      checks++;
      if (mem_bus !== {1'b1, 1'b1, 32'h200, 32'h12345678, 4'hF}) begin
        errors++; $display("FAIL store_stall_%0d: got %h want %h", i, mem_bus,
                           {1'b1, 1'b1, 32'h200, 32'h12345678, 4'hF});
      end
      checks++;
      if ({bus_rr.resp_valid, bus_rr.req_ready} !== 4'b0000) begin
        errors++; $display("FAIL store_quiet_%0d: resp=%b ready=%b want 00/00", i, bus_rr.resp_valid, bus_rr.req_ready);
      end
      @(posedge clk); #1;
    end
    bus_rr.mem_ready = 1'b1; bus_rr.mem_resp_valid = 1'b0; bus_rr.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus_rr.mem_valid !== 1'b1 || bus_rr.resp_valid !== 2'b00) begin
      errors++; $display("FAIL store_handoff: valid=%b resp=%b want 1/00", bus_rr.mem_valid, bus_rr.resp_valid);
    end
    @(posedge clk); #1;
    bus_rr.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_rr !== WAIT || bus_rr.mem_valid !== 1'b0 || bus_rr.resp_valid !== 2'b00) begin
      errors++; $display("FAIL store_wait: state=%0d valid=%b resp=%b want WAIT/0/00",
                         state_rr, bus_rr.mem_valid, bus_rr.resp_valid);
    end
    @(posedge clk); #1;
    bus_rr.mem_resp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_rr.resp_valid !== 2'b10) begin
      errors++; $display("FAIL store_resp: got %b want 10", bus_rr.resp_valid);
    end
    @(posedge clk); #1;
    bus_rr.mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state_rr !== IDLE || bus_rr.req_ready !== 2'b00 || bus_rr.resp_valid !== 2'b00) begin
      errors++; $display("FAIL store_no_ghost_grant: state=%0d ready=%b resp=%b want IDLE/00/00",
                         state_rr, bus_rr.req_ready, bus_rr.resp_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [73:0] outs;
    do_reset();
    @(posedge clk); #1;
    bus_rr.req_valid = 2'b01; bus_rr.req_address[0] = 32'h300;
    bus_rr.req_byte_enable[0] = 4'h3; bus_rr.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_rr.req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_wait_grant: got %b want 01", bus_rr.req_ready);
    end
    @(posedge clk); #1;
    bus_rr.req_valid = 2'b00;
    @(posedge clk); #1;
    bus_rr.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_rr !== WAIT) begin
      errors++; $display("FAIL rst_wait_state: got %0d want WAIT", state_rr);
    end
    #2;
    n_rst = 1'b0;
    bus_rr.mem_resp_valid = 1'b1;
    bus_rr.req_valid = 2'b11;
    #1;
    outs = {bus_rr.req_ready, bus_rr.resp_valid, bus_rr.mem_valid, bus_rr.mem_write,
            bus_rr.mem_address, bus_rr.mem_write_data, bus_rr.mem_byte_enable};
    checks++;
    if (outs !== '0 || state_rr !== IDLE) begin
      errors++; $display("FAIL rst_wait_async: outs=%h state=%0d want 0/IDLE", outs, state_rr);
    end
    repeat (2) @(posedge clk);
    #1;
    bus_rr.mem_resp_valid = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_rr.req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_wait_first_grant: got %b want 01", bus_rr.req_ready);
    end
    init_inputs();
  endtask

  task automatic test_spurious_idle();
    do_reset();
    @(posedge clk); #1;
    bus_rr.mem_ready = 1'b1; bus_rr.mem_resp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus_rr.resp_valid !== 2'b00 || state_rr !== IDLE) begin
        errors++; $display("FAIL spurious_idle_%0d: resp=%b state=%0d want 00/IDLE",
                           i, bus_rr.resp_valid, state_rr);
      end
      @(posedge clk); #1;
    end
    init_inputs();
  endtask

  initial begin
    n_rst = 1'b0;
    init_inputs();
    test_reset();
    test_zero_wait_load();
    test_round_robin();
    test_fixed();
    test_stall_store();
    test_reset_in_wait();
    test_spurious_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
